// File: rtl/cacheline_pkg.sv
// Shared widths, line/beat types and burst FSM states for the cacheline burst adaptor.
package cacheline_pkg;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_BEAT_W = 64;
  localparam int DEF_ADDR_W = 32;

  typedef logic [DEF_LINE_W-1:0] cacheline_t;
  typedef logic [DEF_BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} burst_state_t;
endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// L2 line request/response and pmem burst signals. slave = adaptor view, master = L2 + pmem side.
interface cacheline_burst_adaptor_if
  import cacheline_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              cacheline_read;
  logic              cacheline_write;
  logic [ADDR_W-1:0] cacheline_addr;
  logic [LINE_W-1:0] cacheline_wdata;
  logic [LINE_W-1:0] cacheline_rdata;
  logic              cacheline_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  cacheline_read, cacheline_write, cacheline_addr, cacheline_wdata,
           pmem_rdata, pmem_resp,
    output cacheline_rdata, cacheline_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output cacheline_read, cacheline_write, cacheline_addr, cacheline_wdata,
           pmem_rdata, pmem_resp,
    input  cacheline_rdata, cacheline_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/line_beat_buffer.sv
// Line register: whole-line parallel load, beat-indexed write, beat-indexed read mux.
module line_beat_buffer #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int IDX_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BURST_LEN*BEAT_W-1:0] load_line,
  input  logic                        beat_we,
  input  logic [IDX_W-1:0]            beat_idx,
  input  logic [BEAT_W-1:0]           beat_in,
  output logic [BURST_LEN*BEAT_W-1:0] line,
  output logic [BEAT_W-1:0]           beat_out
);
  logic [BURST_LEN-1:0][BEAT_W-1:0] buf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= load_line;
    end else if (beat_we) begin
      buf_q[beat_idx] <= beat_in;
    end
  end

  assign line     = buf_q;
  assign beat_out = buf_q[beat_idx];
endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Turns one L2 full-line read/write into a BURST_LEN-beat pmem burst and a one-cycle resp.
module cacheline_burst_adaptor
  import cacheline_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adaptor_if.slave bus
);
  localparam int BURST_LEN = LINE_W / BEAT_W;
  localparam int OFF_W     = $clog2(LINE_W / 8);
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  burst_state_t      state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load, beat_we;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] beat_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    load       = 1'b0;
    beat_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // read&write together is an illegal flush request from the L2 and is dropped
        if (bus.cacheline_read ^ bus.cacheline_write) begin
          addr_d  = {bus.cacheline_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          load    = bus.cacheline_write;
          state_d = bus.cacheline_read ? RD_BURST : WR_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (bus.pmem_resp) begin
          beat_we = (state_q == RD_BURST);
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  line_beat_buffer #(
    .BEAT_W   (BEAT_W),
    .BURST_LEN(BURST_LEN),
    .IDX_W    (CNT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_line(bus.cacheline_wdata),
    .beat_we  (beat_we),
    .beat_idx (beat_cnt_q),
    .beat_in  (bus.pmem_rdata),
    .line     (line),
    .beat_out (beat_out)
  );

  // Outputs are gated by state so the L2 never sees stale buffer contents outside DONE.
  assign bus.pmem_read       = (state_q == RD_BURST);
  assign bus.pmem_write      = (state_q == WR_BURST);
  assign bus.pmem_addr       = (state_q == IDLE) ? '0 : addr_q;
  assign bus.pmem_wdata      = (state_q == WR_BURST) ? beat_out : '0;
  assign bus.cacheline_resp  = (state_q == DONE);
  assign bus.cacheline_rdata = (state_q == DONE) ? line : '0;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench: expected lines/write beats queued at request, checked as the DUT emits them.
module tb_cacheline_burst_adaptor;
  import cacheline_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if bus ();

  cacheline_burst_adaptor dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  cacheline_t exp_lines[$];
  beat_t      exp_wbeats[$];
  logic [31:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (bus.cacheline_resp) begin
      if (exp_lines.size() == 0) chk("resp_unexp", 1, 0);
      else chk("rdata", bus.cacheline_rdata, exp_lines.pop_front());
    end else begin
      chk("rdata_idle", bus.cacheline_rdata, 0);
    end
    if (bus.pmem_write && bus.pmem_resp) begin
      if (exp_wbeats.size() == 0) chk("wbeat_unexp", 1, 0);
      else chk("wbeat", bus.pmem_wdata, exp_wbeats.pop_front());
    end
    if (bus.pmem_read || bus.pmem_write) chk("pmem_addr", bus.pmem_addr, exp_addr);
    else if (!bus.cacheline_resp) chk("addr_idle", bus.pmem_addr, 0);
  end

  // Called just after a posedge; leaves the request dropped just after the posedge following resp.
  task automatic run_xfer(input bit is_wr, input logic [31:0] addr, input cacheline_t line,
                          input logic [15:0] pat, input int plen);
    int n, beat;
    exp_addr = {addr[31:5], 5'b0};
    exp_lines.push_back(line);
    if (is_wr) for (int i = 0; i < 4; i++) exp_wbeats.push_back(line[i*64 +: 64]);
    bus.cacheline_addr  = addr;
    bus.cacheline_wdata = is_wr ? line : ~line;
    bus.cacheline_read  = !is_wr;
    bus.cacheline_write = is_wr;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(bus.pmem_read || bus.pmem_write) && n < 20);
    chk("req_lat", n, 1);
    chk("burst_kind", {bus.pmem_read, bus.pmem_write}, is_wr ? 2'b01 : 2'b10);
    bus.cacheline_addr  = ~addr;
    bus.cacheline_wdata = ~line;
    beat = 0;
    for (int i = 0; i < plen; i++) begin
      bus.pmem_resp  = pat[i];
      bus.pmem_rdata = pat[i] ? line[beat*64 +: 64] : 64'hdead_beef_0bad_f00d;
      if (pat[i]) beat++;
      @(posedge clk); #1;
      if (i < plen - 1) chk("resp_early", bus.cacheline_resp, 0);
    end
    bus.pmem_resp = 1'b0;
    chk("resp_pulse", bus.cacheline_resp, 1);
    chk("done_quiet", {bus.pmem_read, bus.pmem_write}, 0);
    @(posedge clk); #1;
    chk("resp_width", bus.cacheline_resp, 0);
    bus.cacheline_read  = 1'b0;
    bus.cacheline_write = 1'b0;
    if (is_wr) chk("wbeats_left", exp_wbeats.size(), 0);
  endtask

  cacheline_t ln;
  logic [15:0] pat;
  int plen;

  initial begin
    bus.cacheline_read  = 1'b0;
    bus.cacheline_write = 1'b0;
    bus.cacheline_addr  = '0;
    bus.cacheline_wdata = '0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;

    #12;
    chk("rst_outs", {bus.pmem_read, bus.pmem_write, bus.cacheline_resp, bus.pmem_addr}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", {bus.pmem_read, bus.pmem_write, bus.cacheline_resp, bus.pmem_addr, bus.pmem_wdata}, 0);

    // 1: plain read, contiguous beats
    run_xfer(0, 32'h0000_1234, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 16'b1111, 4);
    @(posedge clk); #1;

    // 2: write, slices A..D out in order
    run_xfer(1, 32'h0000_5678, {64'hdddd_0004_dddd_0004, 64'hcccc_0003_cccc_0003,
                                64'hbbbb_0002_bbbb_0002, 64'haaaa_0001_aaaa_0001}, 16'b1111, 4);
    @(posedge clk); #1;

    // 3: read with gaps 1,0,0,1,1,0,1
    run_xfer(0, 32'h0001_00ff, {64'h0123_4567_89ab_cdef, 64'hfeed_face_cafe_f00d,
                                64'h5555_aaaa_5555_aaaa, 64'h0f0f_f0f0_0f0f_f0f0}, 16'b1011001, 7);
    @(posedge clk); #1;

    // 4: eviction write then read, back-to-back
    run_xfer(1, 32'h0000_a040, {4{64'h1357_9bdf_2468_ace0}}, 16'b11101, 5);
    run_xfer(0, 32'h0000_b07f, {64'h4, 64'h3, 64'h2, 64'h1}, 16'b1111, 4);
    @(posedge clk); #1;

    // 5: reset after beat 2 of a read
    exp_addr = 32'h0000_2040;
    bus.cacheline_addr = 32'h0000_2044;
    bus.cacheline_read = 1'b1;
    @(posedge clk); #1;
    chk("r5_rd", bus.pmem_read, 1);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 64'h9999_9999_9999_9999;
    @(posedge clk); #1;
    bus.pmem_rdata = 64'h8888_8888_8888_8888;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    rst = 1'b1;
    #1;
    chk("r5_async", {bus.pmem_read, bus.cacheline_resp}, 0);
    @(posedge clk); #1 bus.cacheline_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("r5_idle", {bus.pmem_read, bus.pmem_write, bus.cacheline_resp}, 0);
    run_xfer(0, 32'h0000_2044, {64'h7, 64'h6, 64'h5, 64'h4}, 16'b1111, 4);
    @(posedge clk); #1;

    // 6: read&write together plus a stray pmem_resp in IDLE
    bus.cacheline_read = 1'b1; bus.cacheline_write = 1'b1;
    bus.cacheline_addr = 32'h0000_3000; bus.cacheline_wdata = '1;
    for (int i = 0; i < 10; i++) begin
      bus.pmem_resp  = (i == 4);
      bus.pmem_rdata = 64'hbad0_bad0_bad0_bad0;
      @(posedge clk); #1;
      chk("conflict", {bus.pmem_read, bus.pmem_write, bus.cacheline_resp}, 0);
    end
    bus.pmem_resp = 1'b0;
    bus.cacheline_read = 1'b0; bus.cacheline_write = 1'b0;
    @(posedge clk); #1;
    run_xfer(0, 32'h0000_3000, {64'hd, 64'hc, 64'hb, 64'ha}, 16'b1111, 4);
    @(posedge clk); #1;

    // random mix with random gaps
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 8; w++) ln[w*32 +: 32] = $urandom;
      pat = '0; plen = 0;
      for (int k = 0; k < 4; k++) begin
        plen += $urandom_range(0, 2);
        pat[plen] = 1'b1;
        plen++;
      end
      run_xfer(1'($urandom_range(0, 1)), $urandom, ln, pat, plen);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("lines_left", exp_lines.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
